// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-register stall/flush codes and PC write enable.
// Optional macro HAZARD_PERF_EN adds saturating memory-wait/load-use/redirect counters.
module hazard_ctrl #(
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 im_stall,
    input  logic                 dm_stall,
    input  logic [RF_ADDR_W-1:0] id_rs1_addr,
    input  logic [RF_ADDR_W-1:0] id_rs2_addr,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 ex_mem_r,
    input  logic [RF_ADDR_W-1:0] ex_rd_addr,
    input  logic                 ex_pc_src,
    output logic                 pc_write,
    output logic [1:0]           if_id_sf,
    output logic [1:0]           id_ex_sf,
    output logic [1:0]           ex_mem_sf,
    output logic [1:0]           mem_wb_sf
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          perf_mem_stall,
    output logic [31:0]          perf_lu_stall,
    output logic [31:0]          perf_flush
`endif
);

    localparam logic [1:0] SF_PASS  = 2'b00;
    localparam logic [1:0] SF_STALL = 2'b10;
    localparam logic [1:0] SF_FLUSH = 2'b01;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_KILL} state_t;

    state_t state;
    logic   redir_pend;
    logic   kill_pend;

    logic gstall, taken, lu, kill_slot;
    logic rs1_hit, rs2_hit;
    logic mem_wait_cyc, lu_cyc, flush_cyc;

    assign gstall  = im_stall | dm_stall;
    assign taken   = ex_pc_src | redir_pend;
    assign rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr);
    assign rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr);
    assign lu      = ex_mem_r && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

    // The stale word fetched behind a redirect is killed once the front end is free again.
    assign kill_slot = !gstall && !taken &&
                       ((state == S_WAIT && kill_pend) || state == S_KILL);

    assign mem_wait_cyc = gstall;
    assign flush_cyc    = !gstall && taken;
    assign lu_cyc       = !gstall && !taken && !kill_slot && lu;

    always_comb begin
        pc_write  = 1'b1;
        if_id_sf  = SF_PASS;
        id_ex_sf  = SF_PASS;
        ex_mem_sf = SF_PASS;
        mem_wb_sf = SF_PASS;
        if (mem_wait_cyc) begin
            pc_write  = 1'b0;
            if_id_sf  = SF_STALL;
            id_ex_sf  = SF_STALL;
            ex_mem_sf = SF_STALL;
            mem_wb_sf = SF_STALL;
        end else if (flush_cyc) begin
            if_id_sf = SF_FLUSH;
            id_ex_sf = SF_FLUSH;
        end else if (kill_slot) begin
            if_id_sf = SF_FLUSH;
        end else if (lu_cyc) begin
            pc_write = 1'b0;
            if_id_sf = SF_STALL;
            id_ex_sf = SF_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_RUN;
            redir_pend <= 1'b0;
            kill_pend  <= 1'b0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (gstall) begin
                        state      <= S_WAIT;
                        redir_pend <= ex_pc_src;
                    end else if (ex_pc_src) begin
                        state <= S_KILL;
                    end
                end
                S_WAIT: begin
                    if (gstall) begin
                        redir_pend <= redir_pend | ex_pc_src;
                    end else if (taken) begin
                        state      <= S_KILL;
                        redir_pend <= 1'b0;
                        kill_pend  <= 1'b0;
                    end else begin
                        state     <= S_RUN;
                        kill_pend <= 1'b0;
                    end
                end
                S_KILL: begin
                    if (gstall) begin
                        state      <= S_WAIT;
                        kill_pend  <= 1'b1;
                        redir_pend <= ex_pc_src;
                    end else if (!ex_pc_src) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state      <= S_RUN;
                    redir_pend <= 1'b0;
                    kill_pend  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_mem_stall <= '0;
            perf_lu_stall  <= '0;
            perf_flush     <= '0;
        end else begin
            if (mem_wait_cyc && perf_mem_stall != 32'hFFFF_FFFF)
                perf_mem_stall <= perf_mem_stall + 32'd1;
            if (lu_cyc && perf_lu_stall != 32'hFFFF_FFFF)
                perf_lu_stall <= perf_lu_stall + 32'd1;
            if (flush_cyc && perf_flush != 32'hFFFF_FFFF)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Produces the 2-bit stall/flush codes (sf) consumed by the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus the PC write enable.
- Resolves three hazard sources in priority order: memory wait, branch/jump redirect, load-use.
- Holds a small FSM so that redirects and kill slots that arrive during a memory wait are not lost.
- Sits in the CPU top, beside the pipeline registers.

Parameters:
- RF_ADDR_W, 5, register-file address width.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-low
- im_stall  input  1  instruction-memory access not complete this cycle
- dm_stall  input  1  data-memory access not complete this cycle
- id_rs1_addr  input  RF_ADDR_W  rs1 of instruction in ID
- id_rs2_addr  input  RF_ADDR_W  rs2 of instruction in ID
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- ex_mem_r  input  1  instruction in EX is a load
- ex_rd_addr  input  RF_ADDR_W  rd of instruction in EX
- ex_pc_src  input  1  EX resolved a taken branch or jump
- pc_write  output  1  PC may update
- if_id_sf  output  2  sf code for IF_ID
- id_ex_sf  output  2  sf code for ID_EX
- ex_mem_sf  output  2  sf code for EX_MEM
- mem_wb_sf  output  2  sf code for MEM_WB

Behaviour:
- sf encoding:
  - 2'b00 = pass.
  - 2'b10 = stall (hold).
  - 2'b01 = flush (load bubble).
  - The block never drives 2'b11.
- Outputs are combinational (Mealy) from state, flags and inputs. Only the state and two flags are registered.
- Terms:
  - gstall = im_stall | dm_stall.
  - lu = ex_mem_r & (ex_rd_addr != 0) & ((id_rs1_used & id_rs1_addr == ex_rd_addr) | (id_rs2_used & id_rs2_addr == ex_rd_addr)).
- States: RUN, WAIT, KILL. Flags: redir_pend and kill_pend.
- On reset (rst=0, async): state=RUN, redir_pend=0, kill_pend=0. Outputs then settle to pc_write=1 and all sf=00 (inputs idle).
- Memory-wait output (any state with gstall=1): pc_write=0, all four sf=10.
- Redirect output (taken = ex_pc_src | redir_pend, with gstall=0): pc_write=1, if_id_sf=01, id_ex_sf=01, ex_mem_sf=00, mem_wb_sf=00. Redirect has priority over lu.
- Load-use output (lu=1, no redirect, gstall=0, not suppressed): pc_write=0, if_id_sf=10, id_ex_sf=01, others 00. Lasts one cycle; the load then advances.
- Kill-slot output: if_id_sf=01. This covers synchronous instruction SRAM returning one stale word after a redirect. lu is suppressed, and the remaining outputs follow the redirect/normal rules.
- RUN state:
  - gstall=1: go to WAIT; redir_pend<=ex_pc_src.
  - gstall=0 and ex_pc_src=1: redirect output; go to KILL.
  - otherwise: lu or normal output; stay in RUN.
- WAIT state:
  - gstall=1: memory-wait output; redir_pend<=redir_pend|ex_pc_src; stay in WAIT.
  - gstall=0 and taken: redirect output; clear both flags; go to KILL.
  - gstall=0, kill_pend=1, not taken: kill-slot output; clear kill_pend; go to RUN.
  - gstall=0, neither: lu or normal output; go to RUN.
- KILL state:
  - gstall=1: memory-wait output; kill_pend<=1; redir_pend<=ex_pc_src; go to WAIT.
  - gstall=0 and ex_pc_src=1: redirect output; stay in KILL.
  - gstall=0, otherwise: kill-slot output; go to RUN.
- Boundary rules:
  - Simultaneous gstall and ex_pc_src: the wait wins and the redirect is captured in redir_pend. It is applied exactly once, on the first cycle with gstall=0.
  - lu with ex_rd_addr=0 is never a hazard.
  - Reset mid-WAIT or mid-KILL discards both flags immediately.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs perf_mem_stall, perf_lu_stall and perf_flush, each 32 bits.
  - Counters reset to 0 on rst.
  - Each increments once per cycle of memory-wait, load-use and redirect output respectively.
  - Counters saturate at 32'hFFFF_FFFF.
- Undefined: these ports and the counter registers do not exist. All other behaviour is identical.

Test Plan:
- Release reset, all inputs 0 -> pc_write=1, all sf=00; state RUN for 10 cycles.
- Load-use: ex_mem_r=1, ex_rd_addr=5, id_rs1_used=1, id_rs1_addr=5 for one cycle.
  - Required: pc_write=0, if_id_sf=10, id_ex_sf=01.
  - Same stimulus with ex_rd_addr=0: all sf=00.
- Branch: ex_pc_src=1 for one cycle.
  - Required: if_id_sf=01, id_ex_sf=01, pc_write=1.
  - Next cycle: if_id_sf=01, id_ex_sf=00.
  - Following cycle: all 00.
- ex_pc_src=1 together with dm_stall=1 for 3 cycles, ex_pc_src dropping after cycle 1.
  - Required: 3 cycles of all sf=10 and pc_write=0.
  - Then one redirect cycle, then one kill-slot cycle.
- In KILL, im_stall=1 for 2 cycles -> all sf=10. On release: if_id_sf=01 once, then RUN.
- HAZARD_PERF_EN: 4 memory-wait cycles, 1 load-use, 2 redirects -> perf_mem_stall=4, perf_lu_stall=1, perf_flush=2. Assert rst=0 mid-count -> all counters 0.
